// File: rtl/wavelet_frame_scanner.sv
// wavelet_frame_scanner
// Reads the filter bank's multiplexed output. Each new-sample pulse starts a sweep of the
// channel select over all filters. The sweep captures one truncated wavelet value per channel.
// The captured values then go out as one frame on a valid/ready byte stream:
//   SYNC_BYTE, seq, buf[0..NUM_FILTERS-1], cksum, where cksum = seq ^ buf[0] ^ ... ^ buf[N-1].
//
// Handshake: o_tx_valid and o_tx_data come straight from registers and never depend
// combinationally on i_tx_ready. A byte is transferred at a posedge where valid and ready are
// both high. Until that edge the byte is held stable. The next byte appears in the following
// cycle, with no bubble.
//
// Ports
//   clk                      system clock
//   rst                      asynchronous reset, active low
//   i_sample_strobe          1-cycle pulse: a new sample entered the filters
//   i_wavelet                multiplexed filter output for the current select
//   o_select_output_channel  channel select to the output multiplexer
//   o_tx_data / o_tx_valid   frame byte stream towards the host link
//   i_tx_ready               sink ready
//   i_clear_overrun          clears o_overrun
//   o_busy                   high whenever the FSM is not IDLE
//   o_overrun                sticky: a strobe arrived while a frame was in progress
//   o_dbg_state              current FSM state encoding, for observation
module wavelet_frame_scanner #(
    parameter int           NUM_FILTERS    = 8,
    parameter int           SUM_TRUNCATION = 8,
    parameter int           SETTLE_CYCLES  = 2,
    parameter logic [7:0]   SYNC_BYTE      = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_sample_strobe,
    input  logic [SUM_TRUNCATION-1:0] i_wavelet,
    output logic [7:0]                o_select_output_channel,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    input  logic                      i_clear_overrun,
    output logic                      o_busy,
    output logic                      o_overrun,
    output logic [2:0]                o_dbg_state
);

    localparam int IW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_FILTERS - 1);
    localparam logic [7:0]    LAST_SEL    = 8'(NUM_FILTERS - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SWEEP      = 3'd1,
        SEND_SYNC  = 3'd2,
        SEND_SEQ   = 3'd3,
        SEND_DATA  = 3'd4,
        SEND_CKSUM = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    sel_q, sel_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    cksum_q, cksum_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    buf_q [NUM_FILTERS];
    logic [7:0]    buf_d [NUM_FILTERS];

    logic [7:0]    wav_ext;
    logic [IW-1:0] idx_inc;
    logic          accept;
    logic          cksum_done;

    assign wav_ext    = 8'(i_wavelet);
    assign idx_inc    = idx_q + 1'b1;
    assign accept     = valid_q & i_tx_ready;
    assign cksum_done = (state_q == SEND_CKSUM) && accept;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        cksum_d  = cksum_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        buf_d    = buf_q;

        case (state_q)
            IDLE: begin
                if (i_sample_strobe) begin
                    state_d  = SWEEP;
                    sel_d    = 8'd0;
                    settle_d = '0;
                    // The checksum starts from seq and accumulates during the sweep.
                    cksum_d  = seq_q;
                end
            end
            SWEEP: begin
                if (settle_q == LAST_SETTLE) begin
                    settle_d               = '0;
                    buf_d[sel_q[IW-1:0]]   = wav_ext;
                    cksum_d                = cksum_q ^ wav_ext;
                    if (sel_q == LAST_SEL) begin
                        sel_d   = 8'd0;
                        state_d = SEND_SYNC;
                        data_d  = SYNC_BYTE;
                        valid_d = 1'b1;
                    end else begin
                        sel_d = sel_q + 8'd1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SEND_SYNC: begin
                if (accept) begin
                    data_d  = seq_q;
                    state_d = SEND_SEQ;
                end
            end
            SEND_SEQ: begin
                if (accept) begin
                    data_d  = buf_q[0];
                    idx_d   = '0;
                    state_d = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        data_d  = cksum_q;
                        state_d = SEND_CKSUM;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = buf_q[idx_inc];
                    end
                end
            end
            SEND_CKSUM: begin
                if (accept) begin
                    valid_d = 1'b0;
                    seq_d   = seq_q + 8'd1;
                    // A strobe on the same edge as the final accept chains straight into a new sweep.
                    if (i_sample_strobe) begin
                        state_d  = SWEEP;
                        sel_d    = 8'd0;
                        settle_d = '0;
                        cksum_d  = seq_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Setting the flag takes priority over clearing it.
        if (i_sample_strobe && (state_q != IDLE) && !cksum_done) begin
            ovr_d = 1'b1;
        end else if (i_clear_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sel_q    <= 8'd0;
            settle_q <= '0;
            idx_q    <= '0;
            seq_q    <= 8'd0;
            cksum_q  <= 8'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                buf_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            cksum_q  <= cksum_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            for (int i = 0; i < NUM_FILTERS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign o_select_output_channel = sel_q;
    assign o_tx_data               = data_q;
    assign o_tx_valid              = valid_q;
    assign o_busy                  = (state_q != IDLE);
    assign o_overrun               = ovr_q;
    assign o_dbg_state             = state_q;

endmodule

// File: tb/tb_wavelet_frame_scanner.sv
// Directed bench for wavelet_frame_scanner. Inputs are driven and outputs sampled on the
// negative clock edge. The multiplexer is modelled as one register stage fed from chan_tab.
// Frame bytes expected by the bench are queued in exp_q when the frame is started.
module tb_wavelet_frame_scanner;

    localparam int NF = 8;
    localparam int NB = NF + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_sample_strobe = 1'b0;
    logic [7:0] i_wavelet = 8'd0;
    logic [7:0] o_select_output_channel;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready = 1'b0;
    logic       i_clear_overrun = 1'b0;
    logic       o_busy;
    logic       o_overrun;
    logic [2:0] o_dbg_state;

    logic [7:0] chan_tab [0:NF-1];
    logic [7:0] exp_q [$];
    logic [7:0] seq_model = 8'd0;
    int         errors = 0;
    int         checks = 0;

    wavelet_frame_scanner #(
        .NUM_FILTERS(NF), .SUM_TRUNCATION(8), .SETTLE_CYCLES(2), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .i_sample_strobe(i_sample_strobe), .i_wavelet(i_wavelet),
        .o_select_output_channel(o_select_output_channel), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .i_clear_overrun(i_clear_overrun),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_dbg_state(o_dbg_state)
    );

    // clock / mux model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        i_wavelet <= chan_tab[o_select_output_channel[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},   32'(o_select_output_channel), 32'd0);
        check({tag, "_data"},  32'(o_tx_data), 32'd0);
        check({tag, "_valid"}, 32'(o_tx_valid), 32'd0);
        check({tag, "_busy"},  32'(o_busy), 32'd0);
        check({tag, "_ovr"},   32'(o_overrun), 32'd0);
        check({tag, "_state"}, 32'(o_dbg_state), 32'd0);
    endtask

    // queue the expected bytes of one frame from the current channel table
    task automatic push_frame(input logic [7:0] seq);
        logic [7:0] ck;
        ck = seq;
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        for (int k = 0; k < NF; k++) begin
            exp_q.push_back(chan_tab[k]);
            ck = ck ^ chan_tab[k];
        end
        exp_q.push_back(ck);
    endtask

    task automatic send_strobe();
        @(negedge clk);
        i_sample_strobe = 1'b1;
        @(negedge clk);
        i_sample_strobe = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        i_clear_overrun = 1'b1;
        @(negedge clk);
        i_clear_overrun = 1'b0;
    endtask

    // Receive one frame. pct = ready probability in percent. strobe_at / clear_at pulse
    // those inputs on the cycle byte number N is presented (-1 = never).
    task automatic recv_frame(input int pct, input int strobe_at, input int clear_at);
        int         cnt = 0;
        int         guard = 0;
        logic       stalled = 1'b0;
        logic       rdy;
        logic [7:0] held = 8'd0;
        logic [7:0] e;
        while (cnt < NB && guard < 2000) begin
            if (o_tx_valid) begin
                if (stalled) check("hold_data", 32'(o_tx_data), 32'(held));
                rdy = ($urandom_range(99) < pct);
                i_tx_ready      = rdy;
                i_sample_strobe = (cnt == strobe_at);
                i_clear_overrun = (cnt == clear_at);
                if (rdy) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                    check("byte", 32'(o_tx_data), 32'(e));
                    cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = o_tx_data;
                end
            end else begin
                if (stalled) check("hold_valid", 32'(o_tx_valid), 32'd1);
                stalled         = 1'b0;
                i_tx_ready      = 1'b0;
                i_sample_strobe = 1'b0;
                i_clear_overrun = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        i_sample_strobe = 1'b0;
        i_clear_overrun = 1'b0;
        i_tx_ready      = 1'b0;
        check("frame_len", 32'(cnt), 32'(NB));
        check("valid_after", 32'(o_tx_valid), 32'd0);
        check("busy_after", 32'(o_busy), (strobe_at == NB - 1) ? 32'd1 : 32'd0);
        seq_model = seq_model + 8'd1;
    endtask

    initial begin
        int vcnt;
        for (int k = 0; k < NF; k++) chan_tab[k] = 8'h10 + 8'(k);

        // 1: reset held low with inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            i_sample_strobe = 1'(i);
            i_tx_ready      = 1'(i >> 1);
            i_clear_overrun = ~1'(i);
        end
        @(negedge clk);
        check_reset_outputs("reset");
        i_sample_strobe = 1'b0;
        i_tx_ready      = 1'b0;
        i_clear_overrun = 1'b0;
        rst = 1'b1;
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_tx_valid) vcnt++;
        end
        check("idle_no_valid", 32'(vcnt), 32'd0);

        // 2: single frame with ready held high, then the select sweep is traced
        push_frame(seq_model);
        send_strobe();
        for (int i = 0; i < 2 * NF; i++) begin
            check("sweep_sel", 32'(o_select_output_channel), 32'(i / 2));
            check("sweep_busy", 32'(o_busy), 32'd1);
            @(negedge clk);
        end
        check("sync_valid", 32'(o_tx_valid), 32'd1);
        check("sync_data", 32'(o_tx_data), 32'hA5);
        check("sync_sel", 32'(o_select_output_channel), 32'd0);
        recv_frame(100, -1, -1);

        // second frame: the channel table is scrambled after the sweep, so the snapshot must be sent
        push_frame(seq_model);
        send_strobe();
        repeat (2 * NF) @(negedge clk);
        for (int k = 0; k < NF; k++) chan_tab[k] = 8'hEE;
        recv_frame(100, -1, -1);
        for (int k = 0; k < NF; k++) chan_tab[k] = 8'h10 + 8'(k);

        // 3: random backpressure
        push_frame(seq_model);
        send_strobe();
        recv_frame(30, -1, -1);

        // 4: overrun behaviour
        push_frame(seq_model);
        send_strobe();
        recv_frame(100, 4, -1);
        check("ovr_set", 32'(o_overrun), 32'd1);
        pulse_clear();
        check("ovr_clear", 32'(o_overrun), 32'd0);
        push_frame(seq_model);
        send_strobe();
        recv_frame(100, 5, 5);
        check("ovr_set_wins", 32'(o_overrun), 32'd1);
        pulse_clear();
        check("ovr_clear2", 32'(o_overrun), 32'd0);
        push_frame(seq_model);
        push_frame(seq_model + 8'd1);
        send_strobe();
        recv_frame(100, NB - 1, -1);
        check("ovr_chain", 32'(o_overrun), 32'd0);
        recv_frame(100, -1, -1);

        // 5: 257 frames so the sequence number wraps
        for (int f = 0; f < 257; f++) begin
            for (int k = 0; k < NF; k++) chan_tab[k] = 8'(f * 7 + k * 29 + 3);
            push_frame(seq_model);
            send_strobe();
            recv_frame(100, -1, -1);
        end

        // 6a: reset mid-sweep
        send_strobe();
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_sweep");
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        seq_model = 8'd0;
        push_frame(seq_model);
        send_strobe();
        recv_frame(100, -1, -1);

        // 6b: reset mid-SEND_DATA with overrun set
        send_strobe();
        i_tx_ready = 1'b1;
        repeat (2 * NF + 2) @(negedge clk);
        i_sample_strobe = 1'b1;
        @(negedge clk);
        i_sample_strobe = 1'b0;
        check("pre_rst_state", 32'(o_dbg_state), 32'd4);
        check("pre_rst_ovr", 32'(o_overrun), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_data");
        @(negedge clk);
        rst = 1'b1;
        i_tx_ready = 1'b0;
        exp_q.delete();
        seq_model = 8'd0;
        push_frame(seq_model);
        send_strobe();
        recv_frame(100, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
